// File: rtl/asmd_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
package asmd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  // Width needed to hold an index in 0..n-1 (n >= 2).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/asmd_multiplier.sv
// Shift-add multiplier: ready=1 when idle, start sampled while ready,
// ready drops the cycle after start and returns with a valid product.
module asmd_multiplier #(
  parameter int word_length = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [word_length-1:0]   word0,
  input  logic [word_length-1:0]   word1,
  input  logic                     start,
  output logic [2*word_length-1:0] product,
  output logic                     ready
);

  localparam int CW = $clog2(word_length + 1);

  logic                     r_busy;
  logic [2*word_length-1:0] r_mcand;
  logic [2*word_length-1:0] r_prod;
  logic [word_length-1:0]   r_mplier;
  logic [CW-1:0]            r_cnt;

  // Load operands on start, then one add/shift step per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (!r_busy) begin
      if (start) begin
        r_mcand  <= {{word_length{1'b0}}, word0};
        r_mplier <= word1;
        r_prod   <= '0;
        r_cnt    <= CW'(word_length);
        r_busy   <= 1'b1;
      end
    end else begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

  assign ready   = !r_busy;
  assign product = r_prod;

endmodule

// File: rtl/asmd_rr_picker.sv
// Combinational round-robin selector: first set request at or above rr_ptr, wrapping.
module asmd_rr_picker
  import asmd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic               any_req,
  output logic [GW-1:0]      grant_idx
);

  localparam int unsigned N = NUM_REQ;

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    any_req   = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx[GW-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = idx[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/asmd_mult_arbiter.sv
// Round-robin arbiter sharing one asmd_multiplier among NUM_REQ requesters.
module asmd_mult_arbiter
  import asmd_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int word_length = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*word_length-1:0] req_word0,
  input  logic [NUM_REQ*word_length-1:0] req_word1,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             done,
  output logic [2*word_length-1:0]       product_out,
  output logic                           busy,
  output logic [word_length-1:0]         mul_word0,
  output logic [word_length-1:0]         mul_word1,
  output logic                           mul_start,
  input  logic [2*word_length-1:0]       mul_product,
  input  logic                           mul_ready
);

  localparam int GW = clog2(NUM_REQ);

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  logic [GW-1:0]            r_rr_ptr;
  logic [GW-1:0]            r_grant;
  logic [word_length-1:0]   r_word0;
  logic [word_length-1:0]   r_word1;
  logic [2*word_length-1:0] r_product;
  logic                     w_any_req;
  logic [GW-1:0]            w_grant_idx;
  logic                     w_take;

  asmd_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req       (req),
    .rr_ptr    (r_rr_ptr),
    .any_req   (w_any_req),
    .grant_idx (w_grant_idx)
  );

  assign w_take = (r_state == IDLE) && w_any_req && mul_ready;

  // Next-state logic for the start/ready handshake sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_take)     w_state_nxt = ISSUE;
      ISSUE:                     w_state_nxt = WAIT_LOW;
      WAIT_LOW:  if (!mul_ready) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (mul_ready)  w_state_nxt = DONE;
      DONE:                      w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant/operand latch, product capture and round-robin pointer advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_word0   <= '0;
      r_word1   <= '0;
      r_product <= '0;
    end else begin
      if (w_take) begin
        r_grant <= w_grant_idx;
        r_word0 <= req_word0[w_grant_idx*word_length +: word_length];
        r_word1 <= req_word1[w_grant_idx*word_length +: word_length];
      end
      if (r_state == WAIT_DONE && mul_ready) r_product <= mul_product;
      if (r_state == DONE) begin
        r_rr_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);
      end
    end
  end

  // One-hot ack/done pulses decoded from the state register.
  always_comb begin
    ack  = '0;
    done = '0;
    if (r_state == ISSUE) ack[r_grant]  = 1'b1;
    if (r_state == DONE)  done[r_grant] = 1'b1;
  end

  assign mul_start   = (r_state == ISSUE);
  assign busy        = (r_state != IDLE);
  assign mul_word0   = r_word0;
  assign mul_word1   = r_word1;
  assign product_out = r_product;

endmodule

// File: tb/tb_asmd_mult_arbiter.sv
// Bench for asmd_mult_arbiter driving the real asmd_multiplier.
module tb_asmd_mult_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   req_word0;
  logic [NR*W-1:0]   req_word1;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     done;
  logic [2*W-1:0]    product_out;
  logic              busy;
  logic [W-1:0]      mul_word0;
  logic [W-1:0]      mul_word1;
  logic              mul_start;
  logic [2*W-1:0]    mul_product;
  logic              mul_ready;

  logic [W-1:0] opa [NR];
  logic [W-1:0] opb [NR];

  always_comb begin
    req_word0 = '0;
    req_word1 = '0;
    for (int i = 0; i < NR; i++) begin
      req_word0[i*W +: W] = opa[i];
      req_word1[i*W +: W] = opb[i];
    end
  end

  asmd_mult_arbiter #(.NUM_REQ(NR), .word_length(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_word0   (req_word0),
    .req_word1   (req_word1),
    .ack         (ack),
    .done        (done),
    .product_out (product_out),
    .busy        (busy),
    .mul_word0   (mul_word0),
    .mul_word1   (mul_word1),
    .mul_start   (mul_start),
    .mul_product (mul_product),
    .mul_ready   (mul_ready)
  );

  asmd_multiplier #(.word_length(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .word0   (mul_word0),
    .word1   (mul_word1),
    .start   (mul_start),
    .product (mul_product),
    .ready   (mul_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t           sbq[$];
  int             log_id[$];
  logic [2*W-1:0] log_prod[$];
  int             ack_cnt;
  int             done_cnt;
  int             model_ptr;
  int             jobs_target;
  logic [NR-1:0]  drop_mask;

  typedef struct {
    logic [NR-1:0]  req;
    logic [NR-1:0]  drop;
    int             njobs;
    logic [W-1:0]   a [NR];
    logic [W-1:0]   b [NR];
    int             ord [4];
    logic [2*W-1:0] prod [4];
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference round-robin choice, independent of the DUT pointer.
  function automatic int model_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (p + k) % NR;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic monitor();
    if (!reset) begin
      sbq.delete();
      model_ptr = 0;
    end else begin
      if (mul_start !== (ack != '0)) chk("start_vs_ack", 32'(mul_start), 32'(ack != '0));
      if (ack != '0) begin
        int e;
        logic [NR-1:0] oh;
        e = model_pick(req, model_ptr);
        ack_cnt++;
        if (e < 0) begin
          chk("ack_without_req", 32'(ack), 0);
        end else begin
          oh = '0;
          oh[e] = 1'b1;
          chk("ack_id", 32'(ack), 32'(oh));
          chk("ack_word0", 32'(mul_word0), 32'(opa[e]));
          chk("ack_word1", 32'(mul_word1), 32'(opb[e]));
          sbq.push_back('{e, (2*W)'(opa[e]) * (2*W)'(opb[e])});
          if (drop_mask[e]) req[e] = 1'b0;
        end
      end
      if (done != '0) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("done_unexpected", 32'(done), 0);
        end else begin
          exp_t x;
          logic [NR-1:0] oh;
          x = sbq.pop_front();
          oh = '0;
          oh[x.id] = 1'b1;
          chk("done_id", 32'(done), 32'(oh));
          chk("done_product", 32'(product_out), 32'(x.prod));
          log_id.push_back(x.id);
          log_prod.push_back(product_out);
          model_ptr = (x.id + 1) % NR;
        end
        if (jobs_target != 0 && done_cnt >= jobs_target) req = '0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_logs();
    log_id.delete();
    log_prod.delete();
    ack_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) step();
    reset = 1'b1;
    step();
    clear_logs();
  endtask

  task automatic wait_dones(input int n, input int budget);
    int c;
    c = 0;
    while (done_cnt < n && c < budget) begin
      step();
      c++;
    end
    chk("jobs_completed", 32'(done_cnt), 32'(n));
  endtask

  initial begin
    reset       = 1'b0;
    req         = '0;
    drop_mask   = '1;
    jobs_target = 0;
    model_ptr   = 0;
    for (int i = 0; i < NR; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    clear_logs();

    vecs[0].req = 4'b0010; vecs[0].drop = 4'b1111; vecs[0].njobs = 1;
    vecs[0].a = '{8'd0, 8'd13, 8'd0, 8'd0};
    vecs[0].b = '{8'd0, 8'd11, 8'd0, 8'd0};
    vecs[0].ord = '{1, 0, 0, 0};
    vecs[0].prod = '{16'd143, 16'd0, 16'd0, 16'd0};

    vecs[1].req = 4'b1111; vecs[1].drop = 4'b1111; vecs[1].njobs = 4;
    vecs[1].a = '{8'd10, 8'd11, 8'd12, 8'd13};
    vecs[1].b = '{8'd3, 8'd3, 8'd3, 8'd3};
    vecs[1].ord = '{0, 1, 2, 3};
    vecs[1].prod = '{16'd30, 16'd33, 16'd36, 16'd39};

    vecs[2].req = 4'b0101; vecs[2].drop = 4'b0000; vecs[2].njobs = 4;
    vecs[2].a = '{8'd5, 8'd0, 8'd9, 8'd0};
    vecs[2].b = '{8'd7, 8'd0, 8'd4, 8'd0};
    vecs[2].ord = '{0, 2, 0, 2};
    vecs[2].prod = '{16'd35, 16'd36, 16'd35, 16'd36};

    vecs[3].req = 4'b0011; vecs[3].drop = 4'b1111; vecs[3].njobs = 2;
    vecs[3].a = '{8'd255, 8'd0, 8'd0, 8'd0};
    vecs[3].b = '{8'd255, 8'd200, 8'd0, 8'd0};
    vecs[3].ord = '{0, 1, 0, 0};
    vecs[3].prod = '{16'd65025, 16'd0, 16'd0, 16'd0};

    // Reset held for 10 cycles.
    repeat (10) step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_product", 32'(product_out), 0);
    chk("rst_word0", 32'(mul_word0), 0);
    chk("rst_word1", 32'(mul_word1), 0);

    // Released with no requests: stays idle.
    reset = 1'b1;
    repeat (5) step();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ack", 32'(ack), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_start", 32'(mul_start), 0);

    // Table-driven jobs.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < NR; i++) begin
        opa[i] = vecs[v].a[i];
        opb[i] = vecs[v].b[i];
      end
      drop_mask   = vecs[v].drop;
      jobs_target = vecs[v].njobs;
      req         = vecs[v].req;
      wait_dones(vecs[v].njobs, 200);
      repeat (15) step();
      chk($sformatf("v%0d_acks", v), 32'(ack_cnt), 32'(vecs[v].njobs));
      chk($sformatf("v%0d_dones", v), 32'(done_cnt), 32'(vecs[v].njobs));
      for (int j = 0; j < vecs[v].njobs; j++) begin
        chk($sformatf("v%0d_order%0d", v, j),
            (j < log_id.size()) ? 32'(log_id[j]) : 32'hFFFF_FFFF, 32'(vecs[v].ord[j]));
        chk($sformatf("v%0d_prod%0d", v, j),
            (j < log_prod.size()) ? 32'(log_prod[j]) : 32'hFFFF_FFFF, 32'(vecs[v].prod[j]));
      end
      chk($sformatf("v%0d_busy_after", v), 32'(busy), 0);
      chk($sformatf("v%0d_prod_hold", v), 32'(product_out),
          32'(vecs[v].prod[vecs[v].njobs-1]));
    end

    // Reset during WAIT_DONE: pointer restarts at 0, no done pulse.
    do_reset();
    drop_mask   = '1;
    opa[1] = 8'd3; opb[1] = 8'd4;
    jobs_target = 1;
    req         = 4'b0010;
    wait_dones(1, 100);
    repeat (2) step();
    clear_logs();
    jobs_target = 0;
    opa[2] = 8'd6; opb[2] = 8'd7;
    req    = 4'b0100;
    begin
      int c;
      c = 0;
      while (ack_cnt < 1 && c < 50) begin
        step();
        c++;
      end
    end
    chk("mid_ack_seen", 32'(ack_cnt), 1);
    repeat (4) step();
    chk("mid_busy", 32'(busy), 1);
    chk("mid_mul_ready", 32'(mul_ready), 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_ack", 32'(ack), 0);
    chk("async_done", 32'(done), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_start", 32'(mul_start), 0);
    chk("async_product", 32'(product_out), 0);
    chk("async_word0", 32'(mul_word0), 0);
    chk("async_word1", 32'(mul_word1), 0);
    req = '0;
    repeat (3) step();
    reset = 1'b1;
    step();
    clear_logs();
    opa[1] = 8'd5; opb[1] = 8'd5;
    jobs_target = 2;
    req = 4'b0110;
    wait_dones(2, 200);
    repeat (10) step();
    chk("post_rst_first", (log_id.size() > 0) ? 32'(log_id[0]) : 32'hFFFF_FFFF, 1);
    chk("post_rst_second", (log_id.size() > 1) ? 32'(log_id[1]) : 32'hFFFF_FFFF, 2);
    chk("post_rst_prod1", (log_prod.size() > 0) ? 32'(log_prod[0]) : 32'hFFFF_FFFF, 25);
    chk("post_rst_prod2", (log_prod.size() > 1) ? 32'(log_prod[1]) : 32'hFFFF_FFFF, 42);
    chk("post_rst_dones", 32'(done_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
